// File: rtl/cache_ctrl_pkg.sv
// Shared encodings for the cache front-end controller: FSM states and requester ids.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    COMPARE  = 3'd2,
    MEM_WAIT = 3'd3,
    FILL     = 3'd4,
    RESP     = 3'd5
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant; on a tie the port that was not served last wins.
module rr_arbiter2
  import cache_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic update,
  input  logic served_id,
  output logic gnt_valid,
  output logic gnt_id
);

  logic last_served;

  // Reset to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_served <= PORT1;
    end else if (update) begin
      last_served <= served_id;
    end
  end

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = PORT0;
    if (req0 && req1) begin
      gnt_id = ~last_served;
    end else if (req1) begin
      gnt_id = PORT1;
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Two-port front end of the direct-mapped cache: arbitrates, sequences one lookup/fill
// at a time and keeps saturating hit/access statistics.
module cache_port_arbiter
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    req1,
  input  logic [ADDR_W-1:0]       addr0,
  input  logic [ADDR_W-1:0]       addr1,
  output logic                    done0,
  output logic                    done1,
  output logic [DATA_W-1:0]       rdata,
  output logic [ADDR_W-TAG_W-1:0] cache_index,
  output logic                    cache_read,
  output logic                    cache_write,
  output logic [TAG_W-1:0]        cache_wtag,
  output logic [DATA_W-1:0]       cache_wdata,
  input  logic                    cache_valid,
  input  logic [TAG_W-1:0]        cache_tag,
  input  logic [DATA_W-1:0]       cache_data,
  output logic                    mem_rd,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ready,
  input  logic [DATA_W-1:0]       mem_data,
  input  logic                    stat_clr,
  output logic [CNT_W-1:0]        hit_count,
  output logic [CNT_W-1:0]        access_count
);

  localparam int IDX_W = ADDR_W - TAG_W;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              id_q;
  logic              hit_q;
  logic              gnt_valid;
  logic              gnt_id;
  logic [ADDR_W-1:0] addr_sel;
  logic              tag_match;
  logic              resp;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .update    (resp),
    .served_id (id_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign resp        = (state == RESP);
  assign addr_sel    = (gnt_id == PORT1) ? addr1 : addr0;
  assign tag_match   = cache_valid && (cache_tag == addr_q[ADDR_W-1 -: TAG_W]);
  assign cache_index = addr_q[IDX_W-1:0];
  assign cache_wtag  = addr_q[ADDR_W-1 -: TAG_W];
  assign cache_wdata = rdata;
  assign mem_addr    = addr_q;

  // All strobes are registered: each is set on entry to the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cache_read  <= 1'b0;
      cache_write <= 1'b0;
      mem_rd      <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      hit_q       <= 1'b0;
      rdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            addr_q     <= addr_sel;
            id_q       <= gnt_id;
            hit_q      <= 1'b0;
            cache_read <= 1'b1;
            state      <= LOOKUP;
          end
        end
        LOOKUP: begin
          cache_read <= 1'b0;
          state      <= COMPARE;
        end
        COMPARE: begin
          if (tag_match) begin
            rdata <= cache_data;
            hit_q <= 1'b1;
            done0 <= (id_q == PORT0);
            done1 <= (id_q == PORT1);
            state <= RESP;
          end else begin
            mem_rd <= 1'b1;
            state  <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            rdata       <= mem_data;
            mem_rd      <= 1'b0;
            cache_write <= 1'b1;
            state       <= FILL;
          end
        end
        FILL: begin
          cache_write <= 1'b0;
          done0       <= (id_q == PORT0);
          done1       <= (id_q == PORT1);
          state       <= RESP;
        end
        RESP: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Clear wins over the RESP increment; each counter sticks at all-ones on its own.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      hit_count    <= '0;
      access_count <= '0;
    end else if (resp) begin
      access_count <= sat_inc(access_count);
      if (hit_q) begin
        hit_count <= sat_inc(hit_count);
      end
    end
  end

endmodule
